// File: rtl/mctrl_arbiter_if.sv
// Requester and memory-controller signal bundle for mctrl_arbiter.
// The master modport is the arbiter side; slave is the requester/memory side.
interface mctrl_arbiter_if #(
   parameter int NREQ = 4,
   parameter int AW   = 32,
   parameter int DW   = 32
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_write;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    rsp_valid;
   logic [DW-1:0]      rsp_rdata;
   logic               rsp_error;
   logic               mem_valid;
   logic               mem_write;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_wdata;
   logic               mem_ready;
   logic               mem_done;
   logic [DW-1:0]      mem_rdata;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_error,
      output mem_valid, mem_write, mem_addr, mem_wdata,
      input  mem_ready, mem_done, mem_rdata
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error,
      input  mem_valid, mem_write, mem_addr, mem_wdata,
      output mem_ready, mem_done, mem_rdata
   );
endinterface

// File: rtl/mctrl_arbiter.sv
// Round-robin arbiter of NREQ requesters onto one memory port, one transaction in flight.
// req_ready 1 cycle after request seen in IDLE, mem_valid 1 cycle later; holds command under mem_ready backpressure.
module mctrl_arbiter #(
   parameter int NREQ    = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input logic clk,
   input logic reset,
   mctrl_arbiter_if.master bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   typedef struct packed {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   state_t          state;
   cmd_t            cmd;
   cmd_t            sel;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   owner_inc;
   logic [IW-1:0]   gnt_idx;
   logic            gnt_found;
   logic [15:0]     cnt;
   logic [15:0]     cnt_inc;
   logic            tmo_hit;
   logic [NREQ-1:0] req_ready_q;
   logic [NREQ-1:0] rsp_valid_q;
   logic [DW-1:0]   rsp_rdata_q;
   logic            rsp_error_q;
   logic            mem_valid_q;

   // First requester at or after rr_ptr, wrapping; its fields are muxed out for latching.
   always_comb begin
      int j;
      j         = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      sel       = '0;
      for (int i = 0; i < NREQ; i++) begin
         j = int'(rr_ptr) + i;
         if (j >= NREQ) j = j - NREQ;
         if (!gnt_found && bus.req_valid[j]) begin
            gnt_found = 1'b1;
            gnt_idx   = IW'(j);
            sel.write = bus.req_write[j];
            sel.addr  = bus.req_addr[j*AW +: AW];
            sel.wdata = bus.req_wdata[j*DW +: DW];
         end
      end
   end

   assign owner_inc = IW'((int'(owner) + 1) % NREQ);
   assign cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
   // Expiry fires on the edge where the count steps onto TIMEOUT.
   assign tmo_hit   = (cnt == 16'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cmd         <= '0;
         owner       <= '0;
         rr_ptr      <= '0;
         cnt         <= '0;
         req_ready_q <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
         mem_valid_q <= 1'b0;
      end else begin
         req_ready_q <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt_found) begin
                  req_ready_q[gnt_idx] <= 1'b1;
                  owner                <= gnt_idx;
                  cmd                  <= sel;
                  cnt                  <= '0;
                  state                <= ISSUE;
               end
            end
            ISSUE: begin
               cnt <= cnt_inc;
               if (tmo_hit) begin
                  rsp_valid_q[owner] <= 1'b1;
                  rsp_error_q        <= 1'b1;
                  mem_valid_q        <= 1'b0;
                  cmd                <= '0;
                  rr_ptr             <= owner_inc;
                  state              <= IDLE;
               end else if (mem_valid_q && bus.mem_ready) begin
                  mem_valid_q <= 1'b0;
                  state       <= WAIT;
               end else begin
                  mem_valid_q <= 1'b1;
               end
            end
            WAIT: begin
               cnt <= cnt_inc;
               // mem_done wins over a simultaneous expiry.
               if (bus.mem_done) begin
                  rsp_valid_q[owner] <= 1'b1;
                  rsp_rdata_q        <= cmd.write ? '0 : bus.mem_rdata;
                  cmd                <= '0;
                  rr_ptr             <= owner_inc;
                  state              <= IDLE;
               end else if (tmo_hit) begin
                  rsp_valid_q[owner] <= 1'b1;
                  rsp_error_q        <= 1'b1;
                  cmd                <= '0;
                  rr_ptr             <= owner_inc;
                  state              <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_error = rsp_error_q;
   assign bus.mem_valid = mem_valid_q;
   assign bus.mem_write = cmd.write;
   assign bus.mem_addr  = cmd.addr;
   assign bus.mem_wdata = cmd.wdata;
endmodule

// File: tb/tb_mctrl_arbiter.sv
// Directed bench for mctrl_arbiter: fairness, read/write, backpressure, timeout, collision, reset.
module tb_mctrl_arbiter;
   localparam int NREQ = 4;
   localparam int AW   = 32;
   localparam int DW   = 32;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;

   mctrl_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   mctrl_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] exp_addr(input int own);
      return 32'h100 + 32'(own) * 32'h1000;
   endfunction

   function automatic logic [31:0] exp_wdata(input int own);
      return 32'hA5A5_0000 + 32'(own);
   endfunction

   task automatic wait_grant(input int own, input logic drop, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (bus.req_ready == '0 && lat < 20);
      chk("grant", bus.req_ready, 64'(1) << own);
      if (drop) bus.req_valid[own] = 1'b0;
      chk("mem_valid_pre", bus.mem_valid, 0);
   endtask

   // One full transaction; owner 1 is configured as the write requester.
   task automatic run_txn(input int own, input logic [31:0] rd, input int hold,
                          input logic drop, output int lat);
      wait_grant(own, drop, lat);
      @(negedge clk);
      chk("mem_valid", bus.mem_valid, 1);
      chk("mem_addr", bus.mem_addr, exp_addr(own));
      chk("mem_write", bus.mem_write, (own == 1) ? 1 : 0);
      if (own == 1) chk("mem_wdata", bus.mem_wdata, exp_wdata(own));
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk("bp_valid", bus.mem_valid, 1);
         chk("bp_addr", bus.mem_addr, exp_addr(own));
         chk("bp_norsp", bus.rsp_valid, 0);
      end
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("accepted", bus.mem_valid, 0);
      bus.mem_done  = 1'b1;
      bus.mem_rdata = rd;
      @(negedge clk);
      bus.mem_done  = 1'b0;
      bus.mem_rdata = '0;
      chk("rsp_valid", bus.rsp_valid, 64'(1) << own);
      chk("rsp_rdata", bus.rsp_rdata, (own == 1) ? 32'h0 : rd);
      chk("rsp_error", bus.rsp_error, 0);
   endtask

   initial begin
      int lat;
      n_chk          = 0;
      n_pass         = 0;
      reset          = 1'b0;
      bus.req_valid  = '0;
      bus.req_write  = 4'b0010;
      bus.mem_ready  = 1'b0;
      bus.mem_done   = 1'b0;
      bus.mem_rdata  = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_addr[i*AW +: AW]  = exp_addr(i);
         bus.req_wdata[i*DW +: DW] = exp_wdata(i);
      end
      repeat (3) @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_mem_valid", bus.mem_valid, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      reset = 1'b1;

      // Fairness: all four held for eight transactions.
      bus.req_valid = 4'b1111;
      for (int t = 0; t < 8; t++) run_txn(t % 4, 32'hC0DE_0000 + 32'(t), 0, 1'b0, lat);
      bus.req_valid = '0;

      // Single read on requester 0, checking arbitration latency.
      @(negedge clk);
      bus.req_valid = 4'b0001;
      run_txn(0, 32'hDEAD_BEEF, 0, 1'b1, lat);
      chk("grant_latency", lat, 1);

      // Backpressure: mem_ready held low while command must stay put.
      bus.req_valid = 4'b1000;
      run_txn(3, 32'h0BAD_F00D, 5, 1'b1, lat);

      // Idle with nothing pending keeps outputs quiet.
      repeat (2) @(negedge clk);
      chk("idle_req_ready", bus.req_ready, 0);
      chk("idle_mem_valid", bus.mem_valid, 0);
      chk("idle_mem_addr", bus.mem_addr, 0);

      // Timeout on requester 2 after the command is accepted, then a stray mem_done.
      bus.req_valid = 4'b0100;
      wait_grant(2, 1'b1, lat);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         bus.mem_ready = (c == 1);
         chk("tmo_norsp", bus.rsp_valid, 0);
      end
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("tmo_rsp_valid", bus.rsp_valid, 4'b0100);
      chk("tmo_rsp_error", bus.rsp_error, 1);
      chk("tmo_rsp_rdata", bus.rsp_rdata, 0);
      chk("tmo_mem_valid", bus.mem_valid, 0);
      repeat (2) @(negedge clk);
      bus.mem_done  = 1'b1;
      bus.mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      bus.mem_done  = 1'b0;
      bus.mem_rdata = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("stray_done", bus.rsp_valid, 0);
      end

      // Collision: mem_done lands on the expiry edge; rr_ptr now points at 3.
      bus.req_valid = 4'b1000;
      wait_grant(3, 1'b1, lat);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         bus.mem_ready = (c == 1);
         if (c == 9) begin
            bus.mem_done  = 1'b1;
            bus.mem_rdata = 32'h1234_5678;
         end
         chk("col_norsp", bus.rsp_valid, 0);
      end
      @(negedge clk);
      bus.mem_done  = 1'b0;
      bus.mem_rdata = '0;
      chk("col_rsp_valid", bus.rsp_valid, 4'b1000);
      chk("col_rsp_error", bus.rsp_error, 0);
      chk("col_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);

      // Move rr_ptr to 3, then reset mid-transaction in WAIT.
      bus.req_valid = 4'b0100;
      run_txn(2, 32'h5555_AAAA, 0, 1'b1, lat);
      bus.req_valid = 4'b0100;
      wait_grant(2, 1'b1, lat);
      @(negedge clk);
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      reset         = 1'b0;
      #1;
      chk("rst_wait_mem_valid", bus.mem_valid, 0);
      chk("rst_wait_rsp_valid", bus.rsp_valid, 0);
      bus.mem_done  = 1'b1;
      @(negedge clk);
      bus.mem_done  = 1'b0;
      reset         = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("no_stale_rsp", bus.rsp_valid, 0);
      end
      // Requesters 2 and 3 pending: a reset rr_ptr picks 2, a stale one would pick 3.
      bus.req_valid = 4'b1100;
      run_txn(2, 32'h7777_0002, 0, 1'b1, lat);
      bus.req_valid = '0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
